// File: rtl/tetris_video_source.sv
`default_nettype none
// ============================================================================
// Module   : tetris_video_source
// Brief    : 800x600@60 timing generator and Tetris board renderer. It reads
//            a 10x20 playfield RAM and drives {R,G,B}, syncs, de and frame_tick.
//            Optional macro GRID_LINES_EN draws a cell grid over the board.
// Revision : 1.0 - initial release
// ============================================================================
module tetris_video_source #(
    parameter int H_ACTIVE  = 800,
    parameter int H_FP      = 40,
    parameter int H_SYNC    = 128,
    parameter int H_BP      = 88,
    parameter int V_ACTIVE  = 600,
    parameter int V_FP      = 1,
    parameter int V_SYNC    = 4,
    parameter int V_BP      = 23,
    parameter int CELL_PX   = 24,
    parameter int BOARD_X0  = 280,
    parameter int BOARD_Y0  = 60,
    parameter int BORDER_PX = 4
) (
    input  logic        pixclk,
    input  logic        reset,
    output logic [7:0]  cell_addr,
    input  logic [2:0]  cell_data,
    output logic [23:0] rgb,
    output logic        hsync,
    output logic        vsync,
    output logic        de,
    output logic        frame_tick
);
    localparam logic [10:0] c_h_last  = 11'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0]  c_v_last  = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [10:0] c_h_act   = 11'(H_ACTIVE);
    localparam logic [9:0]  c_v_act   = 10'(V_ACTIVE);
    localparam logic [10:0] c_hs_lo   = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] c_hs_hi   = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0]  c_vs_lo   = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]  c_vs_hi   = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [10:0] c_bx_lo   = 11'(BOARD_X0);
    localparam logic [10:0] c_bx_hi   = 11'(BOARD_X0 + 10 * CELL_PX);
    localparam logic [9:0]  c_by_lo   = 10'(BOARD_Y0);
    localparam logic [9:0]  c_by_hi   = 10'(BOARD_Y0 + 20 * CELL_PX);
    localparam logic [10:0] c_ox_lo   = 11'(BOARD_X0 - BORDER_PX);
    localparam logic [10:0] c_ox_hi   = 11'(BOARD_X0 + 10 * CELL_PX + BORDER_PX);
    localparam logic [9:0]  c_oy_lo   = 10'(BOARD_Y0 - BORDER_PX);
    localparam logic [9:0]  c_oy_hi   = 10'(BOARD_Y0 + 20 * CELL_PX + BORDER_PX);
    localparam logic [4:0]  c_px_last = 5'(CELL_PX - 1);

    // Per-pixel flags carried S0 -> S2: {de, hsync, vsync, tick, board, outer, grid}
    localparam int c_fw = 7;

    logic [10:0]     r_hcnt;
    logic [9:0]      r_vcnt;
    logic [4:0]      r_px_x;
    logic [4:0]      r_px_y;
    logic [3:0]      r_col;
    logic [4:0]      r_row;
    logic [c_fw-1:0] r_s1_flags;
    logic [c_fw-1:0] r_s2_flags;

    logic            w_h_wrap;
    logic            w_v_wrap;
    logic [10:0]     w_h_next;
    logic [9:0]      w_v_next;
    logic            w_board0;
    logic            w_grid0;
    logic [7:0]      w_addr0;
    logic [c_fw-1:0] w_flags0;

    function automatic logic [23:0] palette(input logic [2:0] idx);
        case (idx)
            3'd0:    return 24'h000000;
            3'd1:    return 24'h00FFFF;
            3'd2:    return 24'hFFFF00;
            3'd3:    return 24'hA000F0;
            3'd4:    return 24'h00F000;
            3'd5:    return 24'hF00000;
            3'd6:    return 24'h0000F0;
            default: return 24'hF0A000;
        endcase
    endfunction

    always_comb begin
        w_h_wrap = (r_hcnt == c_h_last);
        w_v_wrap = (r_vcnt == c_v_last);
        w_h_next = w_h_wrap ? 11'd0 : r_hcnt + 11'd1;
        w_v_next = w_v_wrap ? 10'd0 : r_vcnt + 10'd1;
    end

    always_ff @(posedge pixclk) begin
        if (reset) begin
            r_hcnt <= '0;
            r_vcnt <= '0;
        end else begin
            r_hcnt <= w_h_next;
            if (w_h_wrap) begin
                r_vcnt <= w_v_next;
            end
        end
    end

    // Cell coordinates are tracked incrementally; they reload at the board origin.
    always_ff @(posedge pixclk) begin
        if (reset) begin
            r_px_x <= '0;
            r_col  <= '0;
            r_px_y <= '0;
            r_row  <= '0;
        end else begin
            if (w_h_next == c_bx_lo) begin
                r_px_x <= '0;
                r_col  <= '0;
            end else if (r_px_x == c_px_last) begin
                r_px_x <= '0;
                r_col  <= r_col + 4'd1;
            end else begin
                r_px_x <= r_px_x + 5'd1;
            end
            if (w_h_wrap) begin
                if (w_v_next == c_by_lo) begin
                    r_px_y <= '0;
                    r_row  <= '0;
                end else if (r_px_y == c_px_last) begin
                    r_px_y <= '0;
                    r_row  <= r_row + 5'd1;
                end else begin
                    r_px_y <= r_px_y + 5'd1;
                end
            end
        end
    end

    always_comb begin
        w_board0 = (r_hcnt >= c_bx_lo) && (r_hcnt < c_bx_hi) &&
                   (r_vcnt >= c_by_lo) && (r_vcnt < c_by_hi);
`ifdef GRID_LINES_EN
        w_grid0  = (r_px_x == 5'd0) || (r_px_y == 5'd0);
`else
        w_grid0  = 1'b0;
`endif
        // row*10 + col as shifts and adds
        w_addr0  = {r_row, 3'b000} + {2'b00, r_row, 1'b0} + {4'b0000, r_col};
        w_flags0 = {(r_hcnt < c_h_act) && (r_vcnt < c_v_act),
                    (r_hcnt >= c_hs_lo) && (r_hcnt <= c_hs_hi),
                    (r_vcnt >= c_vs_lo) && (r_vcnt <= c_vs_hi),
                    (r_hcnt == 11'd0) && (r_vcnt == c_v_act),
                    w_board0,
                    (r_hcnt >= c_ox_lo) && (r_hcnt < c_ox_hi) &&
                    (r_vcnt >= c_oy_lo) && (r_vcnt < c_oy_hi),
                    w_grid0};
    end

    always_ff @(posedge pixclk) begin
        if (reset) begin
            cell_addr  <= '0;
            r_s1_flags <= '0;
            r_s2_flags <= '0;
        end else begin
            if (w_board0) begin
                cell_addr <= w_addr0;
            end
            r_s1_flags <= w_flags0;
            r_s2_flags <= r_s1_flags;
        end
    end

    // Output register: flags and RAM data both belong to the same S2 pixel.
    always_ff @(posedge pixclk) begin
        if (reset) begin
            rgb        <= '0;
            de         <= 1'b0;
            hsync      <= 1'b0;
            vsync      <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            de         <= r_s2_flags[6];
            hsync      <= r_s2_flags[5];
            vsync      <= r_s2_flags[4];
            frame_tick <= r_s2_flags[3];
            if (!r_s2_flags[6]) begin
                rgb <= 24'h000000;
            end else if (r_s2_flags[2]) begin
                rgb <= r_s2_flags[0] ? 24'h303030 : palette(cell_data);
            end else if (r_s2_flags[1]) begin
                rgb <= 24'h808080;
            end else begin
                rgb <= 24'h202020;
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_tetris_video_source.sv
`default_nettype none
// ============================================================================
// Module   : tb_tetris_video_source
// Brief    : Directed self-checking bench for tetris_video_source on a scaled
//            56x56 raster (board at 8,4 with 2-pixel cells, 2-pixel border).
// Revision : 1.0 - initial release
// ============================================================================
module tb_tetris_video_source;
    localparam int HT = 56;
    localparam int VT = 56;
    localparam int FR = HT * VT;

    logic        pixclk = 1'b0;
    logic        reset  = 1'b1;
    logic [7:0]  cell_addr;
    logic [2:0]  cell_data;
    logic [23:0] rgb;
    logic        hsync;
    logic        vsync;
    logic        de;
    logic        frame_tick;

    int n = 0;
    bit ram_const = 1'b0;
    int n_checks = 0;
    int n_fail = 0;

    logic [23:0] pal [8] = '{24'h000000, 24'h00FFFF, 24'hFFFF00, 24'hA000F0,
                             24'h00F000, 24'hF00000, 24'h0000F0, 24'hF0A000};

    tetris_video_source #(
        .H_ACTIVE(40), .H_FP(4), .H_SYNC(8), .H_BP(4),
        .V_ACTIVE(48), .V_FP(1), .V_SYNC(4), .V_BP(3),
        .CELL_PX(2), .BOARD_X0(8), .BOARD_Y0(4), .BORDER_PX(2)
    ) dut (
        .pixclk     (pixclk),
        .reset      (reset),
        .cell_addr  (cell_addr),
        .cell_data  (cell_data),
        .rgb        (rgb),
        .hsync      (hsync),
        .vsync      (vsync),
        .de         (de),
        .frame_tick (frame_tick)
    );

    always #5 pixclk = ~pixclk;

    // n is the cycle index since the last reset edge; the RAM answers one cycle late.
    always @(posedge pixclk) begin
        if (reset) n <= 0;
        else       n <= n + 1;
        cell_data <= ram_const ? 3'd5 : cell_addr[2:0];
    end

    function automatic int pos(input int f, input int h, input int v);
        return f * FR + v * HT + h;
    endfunction

    function automatic logic [23:0] board_px(input logic [23:0] colour, input bit on_grid);
        bit g;
        g = on_grid;
`ifndef GRID_LINES_EN
        g = 1'b0;
`endif
        return g ? 24'h303030 : colour;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_n(input int target);
        int k;
        k = 0;
        while (n != target && k < 8000) begin
            @(negedge pixclk);
            k++;
        end
        chk("wait_reached", 64'(n), 64'(target));
    endtask

    initial begin
        int run, k;
        int hs_r1, hs_r2, hs_len, vs_r1, vs_r2, vs_len, ft1, ft2, ft_cnt;
        logic hs_prev, vs_prev;

        for (int i = 0; i < 4; i++) begin
            @(negedge pixclk);
            chk("reset_state", {rgb, hsync, vsync, de, frame_tick, cell_addr}, 64'd0);
        end
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("post_release_idle", {rgb, hsync, vsync, de}, 64'd0);
            @(negedge pixclk);
        end
        chk("de_rise_n", 64'(n), 64'd3);
        chk("de_rise", {63'd0, de}, 64'd1);
        chk("rgb_0_0", rgb, 24'h202020);
        run = 0;
        while (de === 1'b1 && run < 100) begin
            run++;
            @(negedge pixclk);
        end
        chk("de_run", 64'(run), 64'd40);

        hs_r1 = -1; hs_r2 = -1; hs_len = 0; vs_r1 = -1; vs_r2 = -1; vs_len = 0;
        ft1 = -1; ft2 = -1; ft_cnt = 0; hs_prev = hsync; vs_prev = vsync; k = 0;
        while (n < 6300 && k < 8000) begin
            @(negedge pixclk);
            k++;
            if (hsync && !hs_prev) begin
                if (hs_r1 < 0) hs_r1 = n; else if (hs_r2 < 0) hs_r2 = n;
            end
            if (hsync && hs_r1 >= 0 && hs_r2 < 0) hs_len++;
            if (vsync && !vs_prev) begin
                if (vs_r1 < 0) vs_r1 = n; else if (vs_r2 < 0) vs_r2 = n;
            end
            if (vsync && vs_r1 >= 0 && vs_r2 < 0) vs_len++;
            if (frame_tick) begin
                ft_cnt++;
                if (ft1 < 0) ft1 = n; else if (ft2 < 0) ft2 = n;
            end
            hs_prev = hsync;
            vs_prev = vsync;
        end
        chk("hsync_first_rise", 64'(hs_r1), 64'd47);
        chk("hsync_width", 64'(hs_len), 64'd8);
        chk("hsync_period", 64'(hs_r2 - hs_r1), 64'd56);
        chk("vsync_first_rise", 64'(vs_r1), 64'd2747);
        chk("vsync_width", 64'(vs_len), 64'd224);
        chk("vsync_period", 64'(vs_r2 - vs_r1), 64'(FR));
        chk("tick_first", 64'(ft1), 64'd2691);
        chk("tick_period", 64'(ft2 - ft1), 64'(FR));
        chk("tick_count", 64'(ft_cnt), 64'd2);

        for (int c = 0; c < 10; c++) begin
            wait_n(pos(2, 8 + 2 * c, 5) + 1);
            chk("addr_row0", cell_addr, 64'(c));
        end
        wait_n(pos(2, 30, 5) + 1);
        chk("addr_hold", cell_addr, 64'd9);
        wait_n(pos(2, 8, 7) + 3);
        chk("grid_px_8_7", rgb, board_px(24'hFFFF00, 1'b1));
        for (int c = 0; c < 8; c++) begin
            wait_n(pos(2, 9 + 2 * c, 7) + 3);
            chk("palette_row1", rgb, pal[(10 + c) % 8]);
        end
        wait_n(pos(2, 27, 43) + 1);
        chk("addr_last", cell_addr, 64'd199);
        wait_n(pos(2, 27, 43) + 3);
        chk("rgb_last", rgb, 24'hF0A000);
        ram_const = 1'b1;

        wait_n(pos(3, 8, 1) + 3);   chk("bg_8_1", rgb, 24'h202020);
        wait_n(pos(3, 8, 2) + 3);   chk("border_8_2", rgb, 24'h808080);
        wait_n(pos(3, 5, 4) + 3);   chk("bg_5_4", rgb, 24'h202020);
        wait_n(pos(3, 6, 4) + 3);   chk("border_6_4", rgb, 24'h808080);
        wait_n(pos(3, 7, 4) + 3);   chk("border_7_4", rgb, 24'h808080);
        wait_n(pos(3, 28, 4) + 3);  chk("border_28_4", rgb, 24'h808080);
        wait_n(pos(3, 29, 4) + 3);  chk("border_29_4", rgb, 24'h808080);
        wait_n(pos(3, 30, 4) + 3);  chk("bg_30_4", rgb, 24'h202020);
        wait_n(pos(3, 8, 10) + 3);  chk("grid_8_10", rgb, board_px(24'hF00000, 1'b1));
        wait_n(pos(3, 45, 10) + 3); chk("blank_45_10", rgb, 24'h000000);
        wait_n(pos(3, 21, 11) + 3); chk("board_21_11", rgb, 24'hF00000);
        wait_n(pos(3, 10, 45) + 3); chk("border_10_45", rgb, 24'h808080);
        wait_n(pos(3, 10, 46) + 3); chk("bg_10_46", rgb, 24'h202020);
        wait_n(pos(3, 10, 50) + 3); chk("blank_10_50", rgb, 24'h000000);

        // Reset while hsync flags are in flight down the pipeline.
        wait_n(pos(4, 46, 30));
        reset = 1'b1;
        @(negedge pixclk);
        chk("midreset_state", {rgb, hsync, vsync, de, frame_tick, cell_addr}, 64'd0);
        reset = 1'b0;
        for (int i = 1; i < 3; i++) begin
            @(negedge pixclk);
            chk("midreset_flush", {rgb, hsync, vsync, de, frame_tick}, 64'd0);
        end
        @(negedge pixclk);
        chk("midreset_de_rise", {hsync, de}, 64'd1);
        ft_cnt = 0; ft1 = -1; k = 0;
        while (n < 2700 && k < 4000) begin
            @(negedge pixclk);
            k++;
            if (n == pos(0, 27, 43) + 1) chk("restart_addr_last", cell_addr, 64'd199);
            if (frame_tick) begin
                ft_cnt++;
                if (ft1 < 0) ft1 = n;
            end
        end
        chk("restart_tick_first", 64'(ft1), 64'd2691);
        chk("restart_tick_count", 64'(ft_cnt), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
